// File: rtl/upstream_pkg.sv
// upstream_pkg: shared widths, table depth and FSM state type for the upstream processor
package upstream_pkg;
  localparam int CLIENT_W    = 5;
  localparam int DATA_W      = 32;
  localparam int NUM_CLIENTS = 32;
  typedef enum logic [1:0] {IDLE, ORDER_WR, MAX_WR} state_e;
endpackage

// File: rtl/client_table.sv
// client_table: per-client register file with async clear, one write port, one combinational read port
module client_table
  import upstream_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [CLIENT_W-1:0] waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [CLIENT_W-1:0] raddr,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem_q [NUM_CLIENTS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NUM_CLIENTS; i++) mem_q[i] <= '0;
    else if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/upstream_processor_top.sv
// upstream_processor_top: per-client order accumulator and limit table with registered readout.
// Define UPC_LIMIT_CHECK_EN to reject orders whose saturated total would exceed the client's nonzero limit.
module upstream_processor_top
  import upstream_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CLIENT_W-1:0] client_id,
  input  logic [DATA_W-1:0]   amount,
  input  logic                new_order,
  input  logic                new_max,
  output logic [DATA_W-1:0]   accumulated_orders,
  output logic [DATA_W-1:0]   max_to_trade,
  output logic                thenewmax
);
  state_e              state_q, state_d;
  logic [CLIENT_W-1:0] id_q, id_d;
  logic [DATA_W-1:0]   amt_q, amt_d, base_q, acc_rd, max_rd, sat;
  logic [DATA_W:0]     sum;
  logic                acc_we, max_we, ok;
  // The table value for the request is captured while idle, so one read port serves both readout and update
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      amt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      amt_q   <= amt_d;
      base_q  <= state_q == IDLE ? acc_rd : base_q;
    end
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    amt_d   = amt_q;
    if (state_q != IDLE) state_d = IDLE;
    else if (new_max || new_order) begin
      state_d = new_max ? MAX_WR : ORDER_WR;
      id_d    = client_id;
      amt_d   = amount;
    end
  end
  assign sum = {1'b0, base_q} + {1'b0, amt_q};
  assign sat = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`ifdef UPC_LIMIT_CHECK_EN
  logic [DATA_W-1:0] lim_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lim_q <= '0;
    else if (state_q == IDLE) lim_q <= max_rd;
  assign ok = lim_q == '0 || sat <= lim_q;
`else
  assign ok = 1'b1;
`endif
  always_comb begin
    acc_we = state_q == ORDER_WR && ok;
    max_we = state_q == MAX_WR;
  end
  client_table u_acc (
    .clk(clk), .rst_n(rst_n), .we(acc_we), .waddr(id_q), .wdata(sat),
    .raddr(client_id), .rdata(acc_rd)
  );
  client_table u_max (
    .clk(clk), .rst_n(rst_n), .we(max_we), .waddr(id_q), .wdata(amt_q),
    .raddr(client_id), .rdata(max_rd)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      accumulated_orders <= '0;
      max_to_trade       <= '0;
      thenewmax          <= 1'b0;
    end else begin
      accumulated_orders <= acc_we && id_q == client_id ? sat : acc_rd;
      max_to_trade       <= max_we && id_q == client_id ? amt_q : max_rd;
      thenewmax          <= max_we;
    end
endmodule

// File: tb/tb_upstream_processor_top.sv
// tb_upstream_processor_top: directed and random checks against a transaction-level table model
module tb_upstream_processor_top;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  client_id = '0;
  logic [31:0] amount = '0;
  logic        new_order = 1'b0;
  logic        new_max = 1'b0;
  logic [31:0] accumulated_orders, max_to_trade;
  logic        thenewmax;
  int checks = 0;
  int failures = 0;
  logic [31:0] acc_m [32];
  logic [31:0] max_m [32];
  bit          pend_v, pend_max;
  logic [4:0]  pend_id;
  logic [31:0] pend_amt;
  logic [31:0] exp_acc, exp_max;
  logic        exp_pulse;

  upstream_processor_top dut (
    .clk(clk), .rst_n(rst_n), .client_id(client_id), .amount(amount),
    .new_order(new_order), .new_max(new_max),
    .accumulated_orders(accumulated_orders), .max_to_trade(max_to_trade),
    .thenewmax(thenewmax)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      acc_m[i] = '0;
      max_m[i] = '0;
    end
    pend_v = 0;
    exp_acc = '0;
    exp_max = '0;
    exp_pulse = 0;
  endtask

  // A request is taken only when nothing is outstanding; it lands on the following edge
  task automatic model_edge();
    logic [32:0] s;
    bit ok;
    exp_pulse = 0;
    if (pend_v) begin
      if (pend_max) begin
        max_m[pend_id] = pend_amt;
        exp_pulse = 1;
      end else begin
        s = {1'b0, acc_m[pend_id]} + {1'b0, pend_amt};
        if (s > 33'hFFFF_FFFF) s = 33'hFFFF_FFFF;
        ok = 1;
`ifdef UPC_LIMIT_CHECK_EN
        ok = max_m[pend_id] == 0 || s[31:0] <= max_m[pend_id];
`endif
        if (ok) acc_m[pend_id] = s[31:0];
      end
      pend_v = 0;
    end else if (new_max || new_order) begin
      pend_v   = 1;
      pend_max = new_max;
      pend_id  = client_id;
      pend_amt = amount;
    end
    exp_acc = acc_m[client_id];
    exp_max = max_m[client_id];
  endtask

  task automatic step(input logic [4:0] id, input logic [31:0] a, input logic no, input logic nm);
    client_id = id;
    amount = a;
    new_order = no;
    new_max = nm;
    @(posedge clk);
    model_edge();
    #1;
    new_order = 0;
    new_max = 0;
    chk("acc", accumulated_orders, exp_acc);
    chk("max", max_to_trade, exp_max);
    chk("pulse", {31'd0, thenewmax}, {31'd0, exp_pulse});
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_clear();
    chk("rst_acc", accumulated_orders, 32'd0);
    chk("rst_max", max_to_trade, 32'd0);
    chk("rst_pulse", {31'd0, thenewmax}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_acc", accumulated_orders, 32'd0);
    rst_n = 1;
  endtask

  initial begin
    model_clear();
    #2;
    do_reset();
    step(5'h01, 32'd1, 0, 0);
    step(5'h01, 32'd1, 0, 0);
    chk("idle_acc", accumulated_orders, 32'd0);
    chk("idle_max", max_to_trade, 32'd0);
    step(5'h1B, 32'hB0C5, 0, 1);
    step(5'h1B, 32'hB0C5, 0, 0);
    chk("newmax_val", max_to_trade, 32'hB0C5);
    chk("newmax_pulse", {31'd0, thenewmax}, 32'd1);
    step(5'h1B, 32'hB0C5, 0, 0);
    chk("newmax_pulse_end", {31'd0, thenewmax}, 32'd0);
    step(5'h1B, 32'h5C5, 1, 0);
    chk("order_first", accumulated_orders, 32'd0);
    step(5'h1B, 32'h5C5, 0, 0);
    chk("order_second", accumulated_orders, 32'h5C5);
    step(5'h1B, 32'h5C5, 0, 0);
    chk("order_held", accumulated_orders, 32'h5C5);
    chk("order_max_kept", max_to_trade, 32'hB0C5);
    step(5'h03, 32'hFFFF_FFF0, 1, 0);
    step(5'h03, 32'h0, 0, 0);
    step(5'h03, 32'h20, 1, 0);
    step(5'h03, 32'h0, 0, 0);
    chk("sat", accumulated_orders, 32'hFFFF_FFFF);
    step(5'h03, 32'h10, 0, 1);
    step(5'h03, 32'h0, 0, 0);
    step(5'h03, 32'h20, 1, 0);
    step(5'h03, 32'h0, 0, 0);
    step(5'h05, 32'h77, 1, 1);
    step(5'h05, 32'h9, 1, 0);
    step(5'h05, 32'h0, 0, 0);
    chk("both_max", max_to_trade, 32'h77);
    chk("both_acc", accumulated_orders, 32'd0);
    step(5'h07, 32'h40, 1, 0);
    do_reset();
    step(5'h07, 32'h0, 0, 0);
    chk("abort_acc", accumulated_orders, 32'd0);
    for (int i = 0; i < 400; i++)
      step(5'($urandom_range(0, 7)),
           ($urandom % 4 == 0) ? 32'hFFFF_FF00 + 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 1000)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
